self_conv_ctrl: RTL and testbench

- Synthesizable self-convergence sequencer that sits above BISG_TOP and replaces the bench-driven BIST loop.
- Repeatedly resets and re-runs BIST with a growing ScanNum, converts each captured speed code to a delay in ps and tracks dmax.
- Declares convergence after K_TH consecutive runs whose delay change is within EPS.
- Captures a golden signature on the first scan_done of a session and flags any later mismatch.

---
 rtl/self_conv_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_self_conv_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/self_conv_ctrl.sv
// Self-convergence sequencer for BISG_TOP.
// It repeatedly pulses the BIST reset, lets BIST run with a growing ScanNum,
// and converts each captured speed code into a delay in ps. A session is
// declared converged once enough consecutive runs land within EPS of the
// previous delay. The first scan signature of a session becomes the golden
// reference, and any later signature that differs from it clears pass.
module self_conv_ctrl #(
    parameter int SIG_W      = 13,
    parameter int SPD_W      = 10,
    parameter int SCAN_W     = 20,
    parameter int DLY_W      = 16,
    parameter int SCAN_START = 50,
    parameter int SCAN_BASE  = 10,
    parameter int EPS        = 10,
    parameter int K_TH       = 7,
    parameter int MAX_RUNS   = 16,
    parameter int RST_CYC    = 3,
    parameter int SPD_KNEE   = 20,
    parameter int OFF_HI     = 1000,
    parameter int OFF_LO     = 900,
    parameter int STEP       = 10,
    parameter int MODE       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              adpll_lock,
    input  logic              over,
    input  logic              scan_done,
    input  logic [SIG_W-1:0]  sig,
    input  logic [SPD_W-1:0]  speed,
    output logic              bist_rst_n,
    output logic [SCAN_W-1:0] scan_num,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              pass,
    output logic [DLY_W-1:0]  dmax,
    output logic [7:0]        run_cnt,
    output logic [SIG_W-1:0]  golden_sig
);

    localparam int EW   = DLY_W + 4;
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [SCAN_W-1:0] MULT_MAX = SCAN_W'(1) << (SCAN_W - 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOCK,
        S_RST_PULSE,
        S_RUN,
        S_EVAL,
        S_UPDATE,
        S_DONE
    } state_t;

    // Delay in ps for a speed code; the offset steps up above the knee and
    // the sum is clamped to the largest value a DLY_W-bit word can hold.
    function automatic logic [DLY_W-1:0] speed_to_delay(input logic [SPD_W-1:0] spd);
        logic [EW-1:0] off;
        logic [EW-1:0] sum;
        off = (spd > SPD_W'(SPD_KNEE)) ? EW'(OFF_HI) : EW'(OFF_LO);
        sum = off + EW'(STEP) * EW'(spd);
        if (sum > EW'({DLY_W{1'b1}}))
            return '1;
        else
            return sum[DLY_W-1:0];
    endfunction

    // True when two delays differ by no more than EPS, in either direction.
    function automatic logic within_eps(input logic [DLY_W-1:0] a, input logic [DLY_W-1:0] b);
        logic [DLY_W-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= DLY_W'(EPS));
    endfunction

    // Doubling multiplier used after a hit, pinned at MULT_MAX.
    function automatic logic [SCAN_W-1:0] double_mult(input logic [SCAN_W-1:0] m);
        if (m >= MULT_MAX)
            return MULT_MAX;
        else
            return m << 1;
    endfunction

    // Next ScanNum = cur + m*SCAN_BASE, computed wide and clamped to all-ones.
    function automatic logic [SCAN_W-1:0] scan_step(input logic [SCAN_W-1:0] cur,
                                                    input logic [SCAN_W-1:0] m);
        logic [2*SCAN_W-1:0] sum;
        sum = {{SCAN_W{1'b0}}, cur} + ({{SCAN_W{1'b0}}, m} * (2*SCAN_W)'(SCAN_BASE));
        if (sum > {{SCAN_W{1'b0}}, {SCAN_W{1'b1}}})
            return '1;
        else
            return sum[SCAN_W-1:0];
    endfunction

    state_t             state_q;
    logic               bist_rst_n_q;
    logic [SCAN_W-1:0]  scan_num_q;
    logic               busy_q;
    logic               done_q;
    logic               converged_q;
    logic               pass_q;
    logic [DLY_W-1:0]   dmax_q;
    logic [7:0]         run_cnt_q;
    logic [SIG_W-1:0]   golden_sig_q;
    logic [7:0]         hit_cnt_q;
    logic [SCAN_W-1:0]  mult_q;
    logic               golden_vld_q;
    logic [RC_W-1:0]    rst_cnt_q;
    logic               armed_q;
    logic [SPD_W-1:0]   speed_q;

    logic [DLY_W-1:0]   dly_d;
    logic               hit_d;
    logic [SCAN_W-1:0]  scan_next_d;

    assign dly_d       = speed_to_delay(speed_q);
    assign hit_d       = (run_cnt_q != 8'd0) && within_eps(dly_d, dmax_q);
    assign scan_next_d = scan_step(scan_num_q, mult_q);

    // Speed code is only valid while over is high, so hold it for EVAL.
    always_ff @(posedge clk) begin
        if (state_q == S_RUN && over && armed_q)
            speed_q <= speed;
    end

    // Session sequencer: lock wait, BIST reset pulse, run, evaluate, update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bist_rst_n_q <= 1'b1;
            scan_num_q   <= SCAN_W'(SCAN_START);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            converged_q  <= 1'b0;
            pass_q       <= 1'b1;
            dmax_q       <= '0;
            run_cnt_q    <= '0;
            golden_sig_q <= '0;
            hit_cnt_q    <= '0;
            mult_q       <= SCAN_W'(1);
            golden_vld_q <= 1'b0;
            rst_cnt_q    <= '0;
            armed_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        run_cnt_q    <= '0;
                        hit_cnt_q    <= '0;
                        golden_vld_q <= 1'b0;
                        done_q       <= 1'b0;
                        converged_q  <= 1'b0;
                        pass_q       <= 1'b1;
                        mult_q       <= SCAN_W'(1);
                        scan_num_q   <= SCAN_W'(SCAN_START);
                        busy_q       <= 1'b1;
                        bist_rst_n_q <= 1'b1;
                        state_q      <= S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (adpll_lock) begin
                        bist_rst_n_q <= 1'b0;
                        rst_cnt_q    <= '0;
                        state_q      <= S_RST_PULSE;
                    end
                end
                S_RST_PULSE: begin
                    if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                        bist_rst_n_q <= 1'b1;
                        armed_q      <= 1'b0;
                        state_q      <= S_RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!adpll_lock) begin
                        // Abandon this run; counters stay as they were.
                        state_q <= S_WAIT_LOCK;
                    end else begin
                        // over is not trusted in the first cycle after reset release.
                        armed_q <= 1'b1;
                        if (scan_done) begin
                            if (!golden_vld_q) begin
                                golden_sig_q <= sig;
                                golden_vld_q <= 1'b1;
                            end else if (sig != golden_sig_q) begin
                                pass_q <= 1'b0;
                            end
                        end
                        if (over && armed_q)
                            state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (hit_d) begin
                        if (hit_cnt_q != 8'hFF)
                            hit_cnt_q <= hit_cnt_q + 8'd1;
                        mult_q <= (MODE == 1) ? double_mult(mult_q) : SCAN_W'(1);
                    end else begin
                        hit_cnt_q <= '0;
                        mult_q    <= SCAN_W'(1);
                    end
                    dmax_q    <= dly_d;
                    run_cnt_q <= run_cnt_q + 8'd1;
                    state_q   <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (hit_cnt_q >= 8'(K_TH)) begin
                        converged_q <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (run_cnt_q >= 8'(MAX_RUNS)) begin
                        converged_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        scan_num_q   <= scan_next_d;
                        bist_rst_n_q <= 1'b0;
                        rst_cnt_q    <= '0;
                        state_q      <= S_RST_PULSE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bist_rst_n = bist_rst_n_q;
    assign scan_num   = scan_num_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign converged  = converged_q;
    assign pass       = pass_q;
    assign dmax       = dmax_q;
    assign run_cnt    = run_cnt_q;
    assign golden_sig = golden_sig_q;

endmodule

// File: tb/tb_self_conv_ctrl.sv
// Bench for self_conv_ctrl: a behavioural BISG_TOP stand-in drives scan_done,
// sig and over/speed; expected delay and run count are queued when over is
// driven and compared once the controller records the run.
module tb_self_conv_ctrl;

    localparam int RST_CYC = 3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        adpll_lock;
    logic        over;
    logic        scan_done;
    logic [12:0] sig;
    logic [9:0]  speed;
    logic        bist_rst_n;
    logic [19:0] scan_num;
    logic        busy;
    logic        done;
    logic        converged;
    logic        pass;
    logic [15:0] dmax;
    logic [7:0]  run_cnt;
    logic [12:0] golden_sig;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  cnt;
    } exp_t;
    exp_t sb[$];

    logic [19:0] scan1 [8]  = '{50, 60, 80, 120, 200, 360, 680, 1320};
    logic [9:0]  spd2  [16] = '{30, 30, 30, 32, 33, 32, 20, 21, 0, 30, 0, 30, 0, 30, 0, 30};
    logic [19:0] scan2 [16] = '{50, 60, 80, 120, 130, 150, 190, 200, 210, 220, 230, 240, 250, 260, 270, 280};
    logic [15:0] d2    [16] = '{1300, 1300, 1300, 1320, 1330, 1320, 1100, 1210, 900, 1300, 900, 1300, 900, 1300, 900, 1300};

    self_conv_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .adpll_lock (adpll_lock),
        .over       (over),
        .scan_done  (scan_done),
        .sig        (sig),
        .speed      (speed),
        .bist_rst_n (bist_rst_n),
        .scan_num   (scan_num),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .pass       (pass),
        .dmax       (dmax),
        .run_cnt    (run_cnt),
        .golden_sig (golden_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_bist_rst_n"}, bist_rst_n, 1);
        chk({pfx, "_scan_num"},   scan_num,   50);
        chk({pfx, "_busy"},       busy,       0);
        chk({pfx, "_done"},       done,       0);
        chk({pfx, "_converged"},  converged,  0);
        chk({pfx, "_pass"},       pass,       1);
        chk({pfx, "_dmax"},       dmax,       0);
        chk({pfx, "_run_cnt"},    run_cnt,    0);
        chk({pfx, "_golden_sig"}, golden_sig, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for the bist_rst_n pulse, measure its width and the ScanNum it carries.
    task automatic pulse_chk(input logic [19:0] exp_scan);
        int n;
        int low;
        logic [19:0] sc;
        n = 0;
        while (bist_rst_n !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("pulse_seen", (n < 200), 1);
        sc = scan_num;
        low = 0;
        while (bist_rst_n === 1'b0 && low < 50) begin
            tick();
            low++;
        end
        chk("rst_low_cyc", low, RST_CYC);
        chk("scan_num", sc, exp_scan);
        chk("busy_run", busy, 1);
    endtask

    // One BIST run as BISG_TOP would produce it.
    task automatic run_body(input logic [9:0] spd, input int nscan, input logic [12:0] sv,
                            input int bad, input bit same,
                            input logic [15:0] exp_d, input logic [7:0] exp_cnt);
        logic [7:0] prev;
        exp_t e;
        int n;
        prev = run_cnt;
        tick();
        for (int i = 0; i < nscan; i++) begin
            scan_done = 1'b1;
            sig = (i == bad) ? (sv ^ 13'h1) : sv;
            if (same && i == nscan - 1) begin
                over  = 1'b1;
                speed = spd;
                e.d = exp_d;
                e.cnt = exp_cnt;
                sb.push_back(e);
            end
            tick();
        end
        scan_done = 1'b0;
        if (!same) begin
            over  = 1'b1;
            speed = spd;
            e.d = exp_d;
            e.cnt = exp_cnt;
            sb.push_back(e);
            tick();
        end
        over  = 1'b0;
        speed = ~spd;
        sig   = '0;
        n = 0;
        while (run_cnt === prev && n < 20) begin
            tick();
            n++;
        end
        chk("eval_seen", (n < 20), 1);
        e = sb.pop_front();
        chk("dmax", dmax, e.d);
        chk("run_cnt", run_cnt, e.cnt);
    endtask

    task automatic do_run(input logic [9:0] spd, input int nscan, input logic [12:0] sv,
                          input int bad, input bit same, input logic [19:0] exp_scan,
                          input logic [15:0] exp_d, input logic [7:0] exp_cnt);
        pulse_chk(exp_scan);
        run_body(spd, nscan, sv, bad, same, exp_d, exp_cnt);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("done_seen", (n < 20), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        adpll_lock = 1'b0;
        over       = 1'b0;
        scan_done  = 1'b0;
        sig        = '0;
        speed      = '0;
        repeat (3) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();
        check_reset("idle");
        adpll_lock = 1'b1;

        // Session 1: constant speed converges after 8 runs with doubling steps.
        pulse_start();
        for (int k = 0; k < 8; k++)
            do_run(10'd30, 2, 13'h1A5, -1, 1'b0, scan1[k], 16'd1300, 8'(k + 1));
        wait_done();
        chk("s1_converged", converged, 1);
        chk("s1_run_cnt", run_cnt, 8);
        chk("s1_busy", busy, 0);
        chk("s1_pass", pass, 1);
        chk("s1_golden", golden_sig, 13'h1A5);
        chk("s1_bist_rst_n", bist_rst_n, 1);

        // Session 2: misses, exact-EPS hits, knee, signature mismatch, run limit.
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            do_run(spd2[k], 3, 13'h0F0, (k == 2) ? 2 : -1, 1'b1, scan2[k], d2[k], 8'(k + 1));
            if (k == 1) chk("s2_pass_before", pass, 1);
            if (k == 2) chk("s2_pass_after", pass, 0);
            if (k == 2) chk("s2_golden_run2", golden_sig, 13'h0F0);
        end
        wait_done();
        chk("s2_converged", converged, 0);
        chk("s2_run_cnt", run_cnt, 16);
        chk("s2_pass_done", pass, 0);
        chk("s2_golden", golden_sig, 13'h0F0);
        chk("s2_busy", busy, 0);

        // Session 3: start while busy, lock loss mid-run, then async reset.
        pulse_start();
        chk("s3_done_cleared", done, 0);
        do_run(10'd30, 1, 13'h055, -1, 1'b0, 20'd50, 16'd1300, 8'd1);
        pulse_chk(20'd60);
        tick();
        pulse_start();
        chk("s3_start_ignored_cnt", run_cnt, 1);
        chk("s3_start_ignored_busy", busy, 1);
        adpll_lock = 1'b0;
        tick();
        tick();
        chk("s3_lock_loss_cnt", run_cnt, 1);
        chk("s3_lock_loss_busy", busy, 1);
        chk("s3_lock_loss_bist", bist_rst_n, 1);
        adpll_lock = 1'b1;
        pulse_chk(20'd60);
        run_body(10'd30, 1, 13'h055, -1, 1'b0, 16'd1300, 8'd2);
        pulse_chk(20'd80);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
